// File: rtl/run_controller.sv
// run_controller: run/halt/single-step sequencer for the 5-stage core.
// A single pipe_enable gates every pipeline register and the fetch PC.
// The block also keeps the enabled-cycle and retired-instruction counters
// and records why the core last stopped.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_in       program loaded (level); 0 forces IDLE and clears state
//   halt_req       external halt pulse (honoured in RUN only)
//   step_req       single-step pulse (honoured in HALTED only)
//   resume_req     resume pulse (honoured in HALTED, wins over step_req)
//   wb_retire      non-bubble instruction in WB
//   wb_is_halt     EBREAK/ECALL in WB
//   pipe_enable    pipeline advances at this edge (RUN or STEP)
//   running        state is RUN
//   halted         state is HALTED
//   halt_cause     0 none, 1 ebreak, 2 external, 3 watchdog
//   cycle_count    enabled cycles since start
//   instret_count  retired instructions since start
module run_controller #(
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic        halt_req,
  input  logic        step_req,
  input  logic        resume_req,
  input  logic        wb_retire,
  input  logic        wb_is_halt,
  output logic        pipe_enable,
  output logic        running,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  localparam int unsigned CNT_W   = 32;
  localparam logic [1:0]  CAUSE_NONE  = 2'd0;
  localparam logic [1:0]  CAUSE_EBRK  = 2'd1;
  localparam logic [1:0]  CAUSE_EXT   = 2'd2;
  localparam logic [1:0]  CAUSE_WDOG  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         cause_nxt;
  logic [CNT_W-1:0]   cycle_nxt;
  logic [CNT_W-1:0]   instret_nxt;
  logic               wdog_hit;

  // Status decoded straight from the state register.
  assign pipe_enable = (state == RUN) || (state == STEP);
  assign running     = (state == RUN);
  assign halted      = (state == HALTED);

  // Watchdog looks at the pre-increment count, so it trips on the Nth enabled edge.
  assign wdog_hit = pipe_enable && (MAX_CYCLES != 0) &&
                    (CNT_W'(cycle_count + CNT_W'(1)) == CNT_W'(MAX_CYCLES));

  // Next-state, cause and counter update.
  always_comb begin
    state_nxt   = state;
    cause_nxt   = halt_cause;
    cycle_nxt   = cycle_count   + CNT_W'(pipe_enable);
    instret_nxt = instret_count + CNT_W'(pipe_enable & wb_retire);

    if (!start_in) begin
      // Losing the program overrides everything and restarts from scratch.
      state_nxt   = IDLE;
      cause_nxt   = CAUSE_NONE;
      cycle_nxt   = '0;
      instret_nxt = '0;
    end else begin
      unique case (state)
        IDLE: state_nxt = RUN;
        RUN: begin
          if (wb_is_halt) begin
            state_nxt = HALTED;
            cause_nxt = CAUSE_EBRK;
          end else if (halt_req) begin
            state_nxt = HALTED;
            cause_nxt = CAUSE_EXT;
          end else if (wdog_hit) begin
            state_nxt = HALTED;
            cause_nxt = CAUSE_WDOG;
          end
        end
        HALTED: begin
          if (resume_req) begin
            state_nxt = RUN;
            cause_nxt = CAUSE_NONE;
          end else if (step_req) begin
            state_nxt = STEP;
          end
        end
        STEP: begin
          state_nxt = HALTED;
          if (wb_is_halt) cause_nxt = CAUSE_EBRK;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      halt_cause    <= CAUSE_NONE;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      state         <= state_nxt;
      halt_cause    <= cause_nxt;
      cycle_count   <= cycle_nxt;
      instret_count <= instret_nxt;
    end
  end

endmodule
